// File: rtl/serial_addsub_ctrl_if.sv
// Start/busy/done request-and-result bundle for the bit-serial add/sub sequencer.
interface serial_addsub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused LSB-first across WIDTH bits.
// Optional signed saturation on overflow is enabled by defining SERIAL_ADDSUB_SAT_EN.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_addsub_ctrl_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             c_msb;
    logic             sub_r;
`ifdef SERIAL_ADDSUB_SAT_EN
    logic             a_msb;
`endif

    logic             bx_c;
    logic             s_c;
    logic             co_c;
    logic             ovf_c;
    logic             accept_c;
    logic [WIDTH-1:0] final_c;

    // The shared 1-bit add/sub cell; subtraction inverts b here and gets its +1 from carry.
    always_comb begin
        bx_c     = b_sr[0] ^ sub_r;
        s_c      = a_sr[0] ^ bx_c ^ carry;
        co_c     = (a_sr[0] & bx_c) | (a_sr[0] & carry) | (bx_c & carry);
        ovf_c    = c_msb ^ carry;
        accept_c = bus.start && (state != RUN);
    end

    always_comb begin
        final_c = res_sr;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_c) begin
            final_c = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            c_msb      <= 1'b0;
            sub_r      <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
            a_msb      <= 1'b0;
`endif
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.cout   <= 1'b0;
            bus.ovf    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: state <= IDLE;
                RUN: begin
                    res_sr <= {s_c, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= co_c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        c_msb    <= carry;
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                DONE: begin
                    bus.done   <= 1'b1;
                    bus.result <= final_c;
                    bus.cout   <= carry;
                    bus.ovf    <= ovf_c;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Acceptance in IDLE or DONE; the latter gives back-to-back operation.
            if (accept_c) begin
                a_sr     <= bus.a;
                b_sr     <= bus.b;
                sub_r    <= bus.sub;
                carry    <= bus.sub;
                cnt      <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
                a_msb    <= bus.a[WIDTH-1];
`endif
                state    <= RUN;
                bus.busy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed self-checking bench for serial_addsub_ctrl (WIDTH=8), aware of SERIAL_ADDSUB_SAT_EN.
module tb_serial_addsub_ctrl;
    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   n;
    int   busy_n;
    bit   changed;

    serial_addsub_ctrl_if #(.WIDTH(8)) bus ();

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; the accepting edge is the next rising edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 8'h5A;
        bus.b     = 8'hC3;
        bus.sub   = ~sub;
    endtask

    // Counts edges until done, busy samples, and whether result moved before done.
    task automatic wait_done(output int edges, output int busy_cnt, output bit moved);
        logic [7:0] prev;
        prev     = bus.result;
        edges    = -1;
        busy_cnt = 0;
        moved    = 1'b0;
        if (bus.busy === 1'b1) busy_cnt++;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                edges = i;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.result !== prev) moved = 1'b1;
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_cout",   32'(bus.cout),   32'd0);
        chk("rst_ovf",    32'(bus.ovf),    32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 25 + 17
        start_op(8'd25, 8'd17, 1'b0);
        chk("add1_busy_after_start", 32'(bus.busy), 32'd1);
        wait_done(n, busy_n, changed);
        chk("add1_latency",  32'(n),          32'd9);
        chk("add1_busy_cyc", 32'(busy_n),     32'd8);
        chk("add1_busy_in_done", 32'(bus.busy), 32'd0);
        chk("add1_result",   32'(bus.result), 32'd42);
        chk("add1_cout",     32'(bus.cout),   32'd0);
        chk("add1_ovf",      32'(bus.ovf),    32'd0);
        chk("add1_hold",     32'(changed),    32'd0);
        @(posedge clk);
        #1;
        chk("add1_done_pulse", 32'(bus.done),   32'd0);
        chk("add1_result_held", 32'(bus.result), 32'd42);

        // 100 + 50 overflows positive
        start_op(8'd100, 8'd50, 1'b0);
        wait_done(n, busy_n, changed);
        chk("add2_latency", 32'(n), 32'd9);
`ifdef SERIAL_ADDSUB_SAT_EN
        chk("add2_result", 32'(bus.result), 32'h7F);
`else
        chk("add2_result", 32'(bus.result), 32'h96);
`endif
        chk("add2_cout", 32'(bus.cout), 32'd0);
        chk("add2_ovf",  32'(bus.ovf),  32'd1);

        // 5 - 7 borrows
        start_op(8'd5, 8'd7, 1'b1);
        wait_done(n, busy_n, changed);
        chk("sub1_latency", 32'(n),          32'd9);
        chk("sub1_result",  32'(bus.result), 32'hFE);
        chk("sub1_cout",    32'(bus.cout),   32'd0);
        chk("sub1_ovf",     32'(bus.ovf),    32'd0);

        // 0x80 - 1 overflows negative
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(n, busy_n, changed);
`ifdef SERIAL_ADDSUB_SAT_EN
        chk("sub2_result", 32'(bus.result), 32'h80);
`else
        chk("sub2_result", 32'(bus.result), 32'h7F);
`endif
        chk("sub2_cout", 32'(bus.cout), 32'd1);
        chk("sub2_ovf",  32'(bus.ovf),  32'd1);

        // 0xFF + 1 wraps; result must hold the previous value during RUN
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(n, busy_n, changed);
        chk("add3_result", 32'(bus.result), 32'h00);
        chk("add3_cout",   32'(bus.cout),   32'd1);
        chk("add3_ovf",    32'(bus.ovf),    32'd0);
        chk("add3_hold",   32'(changed),    32'd0);

        // 3 + 4 with an ignored request mid-RUN, then a back-to-back 9 + 9
        start_op(8'd3, 8'd4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ign_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 30 && bus.busy === 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("b2b_busy_low", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        chk("ign_done",    32'(bus.done),   32'd1);
        chk("ign_result",  32'(bus.result), 32'd7);
        chk("b2b_accepted", 32'(bus.busy),  32'd1);
        wait_done(n, busy_n, changed);
        chk("b2b_latency", 32'(n),          32'd9);
        chk("b2b_result",  32'(bus.result), 32'd18);
        chk("b2b_hold",    32'(changed),    32'd0);

        // Reset in the middle of RUN discards the operation
        start_op(8'hFF, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy",   32'(bus.busy),   32'd0);
        chk("mid_rst_done",   32'(bus.done),   32'd0);
        chk("mid_rst_result", 32'(bus.result), 32'd0);
        chk("mid_rst_cout",   32'(bus.cout),   32'd0);
        chk("mid_rst_ovf",    32'(bus.ovf),    32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_idle_done", 32'(bus.done), 32'd0);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(n, busy_n, changed);
        chk("post_rst_latency", 32'(n),          32'd9);
        chk("post_rst_result",  32'(bus.result), 32'h00);
        chk("post_rst_cout",    32'(bus.cout),   32'd1);
        chk("post_rst_ovf",     32'(bus.ovf),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
